iobus_uart_tx: RTL
==================

Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter on the MCU IOBUS; the sending counterpart to the serial programmer's receiver.
- The MCU writes bytes to a data register. Bytes queue in a small FIFO and are serialized 8N1, LSB first, on TX.
- A status register is readable through the IOBUS_IN read-data mux.

Parameters:
- CLK_RATE, 50, clock frequency in MHz.
- BAUD, 115200, line rate in bit/s.
- DIV, (CLK_RATE*1_000_000)/BAUD (integer truncation, 434 at defaults), clocks per bit. Derived localparam; elaboration error if DIV < 2.
- ADDR_BASE, 32'h1100_0040, byte address of TXDATA. STATUS is at ADDR_BASE+4.
- FIFO_DEPTH, 16, entries. Must be a power of 2, ≥ 2.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous reset, active-low
- IOBUS_ADDR  in  32  MCU IO address
- IOBUS_OUT  in  32  MCU IO write data
- IOBUS_WR  in  1  MCU IO write strobe, single-cycle
- RD_DATA  out  32  registered read data, feeds the IOBUS_IN mux
- TX  out  1  serial line, idle high
- BUSY  out  1  high when a frame is in progress or the FIFO is non-empty

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - TX=1, BUSY=0, RD_DATA=0.
  - FIFO emptied, OVERRUN=0, FSM=IDLE, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame; TX is 1 from the next cycle.
- TXDATA write (IOBUS_WR=1 and IOBUS_ADDR==ADDR_BASE):
  - Pushes IOBUS_OUT[7:0]; IOBUS_OUT[31:8] ignored.
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and OVERRUN is set (sticky).
- STATUS write (IOBUS_WR=1 and IOBUS_ADDR==ADDR_BASE+4):
  - bit0=1 flushes the FIFO. A frame in flight completes normally.
  - bit3=1 clears OVERRUN.
  - Any other bits are ignored.
  - If flush and clear coincide with an overrun push, flush and clear win.
- STATUS format:
  - [0] full, [1] empty, [2] FSM!=IDLE, [3] OVERRUN.
  - [8 +: log2(FIFO_DEPTH)+1] occupancy count; all other bits 0.
- Read path:
  - RD_DATA is registered each cycle: STATUS when IOBUS_ADDR==ADDR_BASE+4, otherwise 0.
  - One-cycle latency, matching the synchronous memory read.
  - Reading TXDATA returns 0.
- Other addresses: IOBUS writes to other addresses are ignored.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: TX=1. If the FIFO is non-empty: pop the head into an 8-bit shift register, counter=DIV-1, go to START.
  - START: TX=0 for DIV cycles (counter decrements to 0), then DATA with bit index 0.
  - DATA: TX=shift[0] for DIV cycles. At counter 0, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: TX=1 for DIV cycles, then IDLE.
- Timing:
  - Frame = 10*DIV cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle (TX=1), i.e. a frame starts every 10*DIV+1 cycles.
  - TX falls 1 cycle after the cycle in which IDLE sees a non-empty FIFO (the push cycle plus 1 when the FIFO was empty).
- BUSY = (FSM!=IDLE) | !empty, combinational from registers.
- Pointers:
  - Wrap modulo FIFO_DEPTH.
  - Count ranges 0..FIFO_DEPTH; full when count==FIFO_DEPTH.

Decomposition:
- Package otter_io_pkg holds:
  - the uart_tx_state_t enum (IDLE, START, DATA, STOP);
  - the register offsets TXDATA_OFS=0, STATUS_OFS=4;
  - the STATUS bit positions.
- Sub-module sync_fifo (parameters WIDTH and DEPTH):
  - ports push, pop, din, dout, full, empty, count, flush;
  - dout shows the head combinationally (first-word fall-through);
  - same-cycle push+pop when full is legal.

Test Plan:
- Parameters CLK_RATE=1, BAUD=250000 (DIV=4). Write 0x55 to TXDATA.
  -> TX low at push+1 for 4 cycles.
  -> then 1,0,1,0,1,0,1,0, each 4 cycles.
  -> then high 4 cycles; BUSY falls after the STOP state.
- Write 0xA3 then 0x0F in consecutive cycles.
  -> two frames.
  -> second start bit begins exactly 41 cycles after the first.
  -> data bits LSB first (0xA3: 1,1,0,0,0,1,0,1).
- Push 17 bytes with the FSM stalled in its first frame.
  -> STATUS reads full=1, count=16 after one pop? No: the 1st byte pops immediately, so 16 remain and the 17th is accepted.
  -> an 18th write sets OVERRUN=1; byte dropped.
  -> writing STATUS 0x8 clears OVERRUN.
- Read STATUS with the FIFO empty and idle.
  -> RD_DATA=0x0000_0002 one cycle after the address is presented.
  -> RD_DATA=0 for address ADDR_BASE+8.
- Queue 3 bytes, then write STATUS bit0 mid-frame.
  -> the current frame completes; no further frames; empty=1.
- Drop RST_N mid-DATA.
  -> TX=1 and BUSY=0 on the next cycle; the next write starts a clean frame.

Source files
------------

// File: rtl/iobus_uart_tx_pkg.sv
// Shared definitions for the IOBUS UART transmitter: FSM encoding,
// register offsets and STATUS bit layout.
package otter_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    // STATUS read layout; FLUSH and OVERRUN-clear reuse bits 0 and 3 on write
    localparam int unsigned ST_FULL_BIT    = 0;
    localparam int unsigned ST_EMPTY_BIT   = 1;
    localparam int unsigned ST_BUSY_BIT    = 2;
    localparam int unsigned ST_OVERRUN_BIT = 3;
    localparam int unsigned ST_COUNT_LSB   = 8;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVR_BIT = 3;

endpackage

// File: rtl/iobus_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MCU IOBUS: TXDATA pushes into a
// FIFO, STATUS reports FIFO/FSM state and flushes or clears OVERRUN on write.
module iobus_uart_tx
    import otter_io_pkg::*;
#(
    parameter int unsigned CLK_RATE   = 50,
    parameter int unsigned BAUD       = 115200,
    parameter logic [31:0] ADDR_BASE  = 32'h1100_0040,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        TX,
    output logic        BUSY
);
    localparam int unsigned DIV = (CLK_RATE * 1_000_000) / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned NW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("iobus_uart_tx: clocks per bit (DIV) must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("iobus_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    uart_tx_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]     r_bit, w_bit_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic           r_tx, w_tx_nxt;
    logic           r_overrun;
    logic [31:0]    r_rd_data;

    logic           w_sel_tx, w_sel_st, w_wr_tx, w_wr_st;
    logic           w_flush, w_clr_ovr, w_pop;
    logic           w_full, w_empty;
    logic [7:0]     w_dout;
    logic [NW-1:0]  w_count;
    logic [31:0]    w_status;
    logic           w_unused_bits;

    assign w_sel_tx  = (IOBUS_ADDR == ADDR_BASE + TXDATA_OFS);
    assign w_sel_st  = (IOBUS_ADDR == ADDR_BASE + STATUS_OFS);
    assign w_wr_tx   = IOBUS_WR && w_sel_tx;
    assign w_wr_st   = IOBUS_WR && w_sel_st;
    assign w_flush   = w_wr_st && IOBUS_OUT[CTRL_FLUSH_BIT];
    assign w_clr_ovr = w_wr_st && IOBUS_OUT[CTRL_CLR_OVR_BIT];
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_unused_bits = &{1'b0, IOBUS_OUT[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (w_wr_tx),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (IOBUS_OUT[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Clear has priority over a same-cycle overrun so software never loses the clear
    always_ff @(posedge CLK) begin
        if (!RST_N || w_clr_ovr) begin
            r_overrun <= 1'b0;
        end else if (w_wr_tx && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_shift_nxt = w_dout;
                end
            end
            START: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = CNT_RELOAD;
                    w_bit_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = CNT_RELOAD;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line level is registered from the next state so TX never glitches
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        w_status                    = '0;
        w_status[ST_FULL_BIT]       = w_full;
        w_status[ST_EMPTY_BIT]      = w_empty;
        w_status[ST_BUSY_BIT]       = (r_state != IDLE);
        w_status[ST_OVERRUN_BIT]    = r_overrun;
        w_status[ST_COUNT_LSB +: NW] = w_count;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_sel_st ? w_status : '0;
        end
    end

    assign RD_DATA = r_rd_data;
    assign TX      = r_tx;
    assign BUSY    = (r_state != IDLE) || !w_empty;

endmodule
